// File: rtl/fp754_pkg.sv
// Shared single-precision constants, FSM state encoding and class-flag record
// for the IEEE-754 pack/unpack datapath.
package fp754_pkg;

  localparam int unsigned SP_EXP_W = 8;
  localparam int unsigned SP_MAN_W = 23;
  localparam int unsigned SP_BIAS  = 127;

  localparam logic [SP_EXP_W-1:0] EXP_ALL1 = '1;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    HOLD
  } state_t;

  // All-zero means an ordinary normal number.
  typedef struct packed {
    logic zero;
    logic subn;
    logic inf;
    logic nan;
    logic snan;
  } class_t;

  function automatic logic f_sign(input logic [SP_EXP_W+SP_MAN_W:0] w);
    return w[SP_EXP_W+SP_MAN_W];
  endfunction

  function automatic logic [SP_EXP_W-1:0] f_exp(input logic [SP_EXP_W+SP_MAN_W:0] w);
    return w[SP_MAN_W +: SP_EXP_W];
  endfunction

  function automatic logic [SP_MAN_W-1:0] f_frac(input logic [SP_EXP_W+SP_MAN_W:0] w);
    return w[SP_MAN_W-1:0];
  endfunction

endpackage

// File: rtl/ieee754_unpacker_if.sv
// Operand-in / unpacked-out handshake bundle of the IEEE-754 unpacker.
interface ieee754_unpacker_if #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
);
  logic                 in_valid;
  logic                 in_ready;
  logic [EXP_W+MAN_W:0] in_float;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_sign;
  logic [EXP_W+1:0]     out_exp;
  logic [MAN_W:0]       out_sig;
  logic                 out_zero;
  logic                 out_subn;
  logic                 out_inf;
  logic                 out_nan;
  logic                 out_snan;

  modport master (
    output in_valid, in_float, out_ready,
    input  in_ready, out_valid, out_sign, out_exp, out_sig,
           out_zero, out_subn, out_inf, out_nan, out_snan
  );

  modport slave (
    input  in_valid, in_float, out_ready,
    output in_ready, out_valid, out_sign, out_exp, out_sig,
           out_zero, out_subn, out_inf, out_nan, out_snan
  );
endinterface

// File: rtl/fp754_classify.sv
// Combinational field decode of a packed IEEE-754 word into class flags and
// the initial (pre-normalisation) unbiased exponent and significand.
module fp754_classify
  import fp754_pkg::*;
#(
  parameter int unsigned EXP_W = SP_EXP_W,
  parameter int unsigned MAN_W = SP_MAN_W,
  parameter int unsigned BIAS  = SP_BIAS
) (
  input  logic [EXP_W+MAN_W:0] word,
  output logic                 sign,
  output class_t               cls,
  output logic [EXP_W+1:0]     exp,
  output logic [MAN_W:0]       sig
);

  localparam logic [EXP_W+1:0] BIAS_X = (EXP_W+2)'(BIAS);
  localparam logic [EXP_W+1:0] ONE_X  = (EXP_W+2)'(1);

  logic [EXP_W-1:0] efield;
  logic [MAN_W-1:0] frac;

  assign efield = word[MAN_W +: EXP_W];
  assign frac   = word[MAN_W-1:0];
  assign sign   = word[EXP_W+MAN_W];

  // Inf/NaN share the normal path: all-ones minus bias already gives the
  // required exponent and inf's fraction is zero, so only flags differ.
  always_comb begin
    cls = '0;
    exp = {2'b00, efield} - BIAS_X;
    sig = {1'b1, frac};
    if (efield == '0) begin
      if (frac == '0) begin
        cls.zero = 1'b1;
        exp      = '0;
        sig      = '0;
      end else begin
        cls.subn = 1'b1;
        exp      = ONE_X - BIAS_X;
        sig      = {1'b0, frac};
      end
    end else if (efield == '1) begin
      if (frac == '0) begin
        cls.inf = 1'b1;
      end else begin
        cls.nan  = 1'b1;
        cls.snan = ~frac[MAN_W-1];
      end
    end
  end

endmodule

// File: rtl/ieee754_unpacker.sv
// IEEE-754 operand unpacker: decodes a packed word, normalises subnormals one
// bit per cycle, and presents sign/exponent/significand/class on a handshake.
module ieee754_unpacker
  import fp754_pkg::*;
#(
  parameter int unsigned EXP_W = SP_EXP_W,
  parameter int unsigned MAN_W = SP_MAN_W,
  parameter int unsigned BIAS  = SP_BIAS
) (
  input  logic                clk,
  input  logic                reset,
  ieee754_unpacker_if.slave   bus
);

  localparam logic [EXP_W+1:0] ONE_X = (EXP_W+2)'(1);

  state_t           state_q, state_d;
  logic             sign_q, sign_d;
  logic [EXP_W+1:0] exp_q, exp_d;
  logic [MAN_W:0]   sig_q, sig_d;
  class_t           cls_q, cls_d;

  logic             dec_sign;
  class_t           dec_cls;
  logic [EXP_W+1:0] dec_exp;
  logic [MAN_W:0]   dec_sig;

  logic             in_ready;
  logic             accept;

  fp754_classify #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W),
    .BIAS  (BIAS)
  ) u_classify (
    .word (bus.in_float),
    .sign (dec_sign),
    .cls  (dec_cls),
    .exp  (dec_exp),
    .sig  (dec_sig)
  );

  assign in_ready = (state_q == IDLE) || ((state_q == HOLD) && bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      sig_q   <= '0;
      cls_q   <= '0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      sig_q   <= sig_d;
      cls_q   <= cls_d;
    end
  end

  // The output registers double as the normalisation shift registers; an
  // accept in HOLD overrides the hold/retire decision in the same edge.
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    sig_d   = sig_q;
    cls_d   = cls_q;
    case (state_q)
      NORM: begin
        sig_d = sig_q << 1;
        exp_d = exp_q - ONE_X;
        if (sig_q[MAN_W-1]) state_d = HOLD;
      end
      HOLD: begin
        if (bus.out_ready && !bus.in_valid) state_d = IDLE;
      end
      default: ;
    endcase
    if (accept) begin
      sign_d  = dec_sign;
      exp_d   = dec_exp;
      sig_d   = dec_sig;
      cls_d   = dec_cls;
      state_d = dec_cls.subn ? NORM : HOLD;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_sign  = sign_q;
  assign bus.out_exp   = exp_q;
  assign bus.out_sig   = sig_q;
  assign bus.out_zero  = cls_q.zero;
  assign bus.out_subn  = cls_q.subn;
  assign bus.out_inf   = cls_q.inf;
  assign bus.out_nan   = cls_q.nan;
  assign bus.out_snan  = cls_q.snan;

endmodule

// File: tb/tb_ieee754_unpacker.sv
// Directed-vector bench for ieee754_unpacker with hand-computed expectations.
module tb_ieee754_unpacker;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ieee754_unpacker_if bus ();

  ieee754_unpacker dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] flags();
    return {bus.out_zero, bus.out_subn, bus.out_inf, bus.out_nan, bus.out_snan};
  endfunction

  task automatic check_out(input string tag, input logic s, input int e,
                           input logic [23:0] sig, input logic [4:0] fl);
    logic [9:0] ee;
    ee = 10'(e);
    check({tag, ".valid"}, 64'(bus.out_valid), 64'(1));
    check({tag, ".sign"},  64'(bus.out_sign),  64'(s));
    check({tag, ".exp"},   64'(bus.out_exp),   64'(ee));
    check({tag, ".sig"},   64'(bus.out_sig),   64'(sig));
    check({tag, ".flags"}, 64'(flags()),       64'(fl));
  endtask

  // flags order: {zero, subn, inf, nan, snan}
  task automatic run_one(input string tag, input logic [31:0] w, input int lat,
                         input logic s, input int e, input logic [23:0] sig,
                         input logic [4:0] fl);
    int n;
    @(negedge clk);
    bus.in_float  = w;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    check({tag, ".in_ready"}, 64'(bus.in_ready), 64'(1));
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".latency"}, 64'(n), 64'(lat));
    check_out(tag, s, e, sig, fl);
  endtask

  function automatic logic [31:0] mk(input int i);
    return {1'b0, 8'(127 + i), 23'(i * 37 + 5)};
  endfunction

  initial begin
    int n;
    bus.in_valid  = 1'b0;
    bus.in_float  = '0;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst.valid", 64'(bus.out_valid), 64'(0));
    check("rst.sig",   64'(bus.out_sig),   64'(0));
    check("rst.exp",   64'(bus.out_exp),   64'(0));
    check("rst.flags", 64'(flags()),       64'(0));
    reset = 1'b0;
    @(negedge clk);
    check("rst.in_ready", 64'(bus.in_ready), 64'(1));

    // Normals
    run_one("one",  32'h3F800000, 1, 1'b0, 0, 24'h800000, 5'b00000);
    run_one("mpi",  32'hC0490FDB, 1, 1'b1, 1, 24'hC90FDB, 5'b00000);
    // Subnormals
    run_one("sub1", 32'h00000001, 24, 1'b0, -149, 24'h800000, 5'b01000);
    run_one("sub2", 32'h00400000, 2, 1'b0, -127, 24'h800000, 5'b01000);
    // Specials
    run_one("pz",   32'h00000000, 1, 1'b0, 0, 24'h000000, 5'b10000);
    run_one("nz",   32'h80000000, 1, 1'b1, 0, 24'h000000, 5'b10000);
    run_one("inf",  32'h7F800000, 1, 1'b0, 128, 24'h800000, 5'b00100);
    run_one("qnan", 32'h7FC00000, 1, 1'b0, 128, 24'hC00000, 5'b00010);
    run_one("snan", 32'h7F800001, 1, 1'b0, 128, 24'h800001, 5'b00011);

    // Back-pressure in HOLD
    @(negedge clk);
    bus.in_float  = 32'h3F800000;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.in_float = 32'h40000000;
    for (int k = 0; k < 5; k++) begin
      check("stall.in_ready", 64'(bus.in_ready), 64'(0));
      check_out("stall", 1'b0, 0, 24'h800000, 5'b00000);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    check("release.valid", 64'(bus.out_valid), 64'(0));
    check("release.exp",   64'(bus.out_exp),   64'(0));
    check("release.sig",   64'(bus.out_sig),   64'(24'h800000));

    // Back-to-back stream
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_float  = mk(0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_out("stream", 1'b0, i, {1'b1, 23'(i * 37 + 5)}, 5'b00000);
      if (i < 7) bus.in_float = mk(i + 1);
      else       bus.in_valid = 1'b0;
    end

    // Subnormal mid-stream: 0x00100000 needs three shifts
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_float = 32'h3FC00000;
    @(posedge clk);
    @(negedge clk);
    check_out("midA", 1'b0, 0, 24'hC00000, 5'b00000);
    bus.in_float = 32'h00100000;
    @(posedge clk);
    @(negedge clk);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      check("mid.in_ready", 64'(bus.in_ready), 64'(0));
      n++;
      @(negedge clk);
    end
    check("mid.stall", 64'(n), 64'(3));
    check_out("midS", 1'b0, -129, 24'h800000, 5'b01000);
    bus.in_float = 32'h40400000;
    @(posedge clk);
    @(negedge clk);
    check_out("midB", 1'b0, 1, 24'hC00000, 5'b00000);
    bus.in_valid = 1'b0;

    // Reset during normalisation
    @(negedge clk);
    bus.in_float = 32'h00000001;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("norm.valid", 64'(bus.out_valid), 64'(0));
    reset = 1'b1;
    #1;
    check("arst.valid", 64'(bus.out_valid), 64'(0));
    check("arst.sig",   64'(bus.out_sig),   64'(0));
    check("arst.exp",   64'(bus.out_exp),   64'(0));
    check("arst.flags", 64'(flags()),       64'(0));
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("arst.in_ready", 64'(bus.in_ready), 64'(1));
    run_one("post", 32'h3F800000, 1, 1'b0, 0, 24'h800000, 5'b00000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
